// File: rtl/multi_dir_signal_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multi_dir_signal_ctrl
// Purpose  : Timed, demand-actuated traffic-signal sequencer for NUM_DIR
//            approaches with rest-in-green and flashing-yellow mode.
// Revision : 1.0 - initial release
// ============================================================================
module multi_dir_signal_ctrl #(
    parameter int NUM_DIR    = 4,
    parameter int GREEN_CYC  = 16,
    parameter int YELLOW_CYC = 4,
    parameter int ALLRED_CYC = 2,
    parameter int FLASH_HALF = 8,
    parameter int TMR_W      = 8,
    localparam int DIR_W     = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               flash_mode,
    input  logic [NUM_DIR-1:0] demand,
    output logic [NUM_DIR-1:0] red,
    output logic [NUM_DIR-1:0] yellow,
    output logic [NUM_DIR-1:0] green,
    output logic [DIR_W-1:0]   active_dir,
    output logic [1:0]         phase
);

    localparam logic [1:0] c_ph_allred = 2'd0;
    localparam logic [1:0] c_ph_green  = 2'd1;
    localparam logic [1:0] c_ph_yellow = 2'd2;
    localparam logic [1:0] c_ph_flash  = 2'd3;

    localparam logic [TMR_W-1:0] c_green_ld  = TMR_W'(GREEN_CYC - 1);
    localparam logic [TMR_W-1:0] c_yellow_ld = TMR_W'(YELLOW_CYC - 1);
    localparam logic [TMR_W-1:0] c_allred_ld = TMR_W'(ALLRED_CYC - 1);
    localparam logic [TMR_W-1:0] c_flash_ld  = TMR_W'(FLASH_HALF - 1);
    localparam logic [DIR_W-1:0] c_last_dir  = DIR_W'(NUM_DIR - 1);

    logic [1:0]         r_phase;
    logic [TMR_W-1:0]   r_timer;
    logic [DIR_W-1:0]   r_active;
    logic               r_flash_on;
    logic [TMR_W-1:0]   r_flash_cnt;
    logic [NUM_DIR-1:0] r_red;
    logic [NUM_DIR-1:0] r_yellow;
    logic [NUM_DIR-1:0] r_green;

    logic [1:0]         w_phase_nxt;
    logic [TMR_W-1:0]   w_timer_nxt;
    logic [DIR_W-1:0]   w_active_nxt;
    logic               w_flash_on_nxt;
    logic [TMR_W-1:0]   w_flash_cnt_nxt;
    logic [NUM_DIR-1:0] w_red_nxt;
    logic [NUM_DIR-1:0] w_yellow_nxt;
    logic [NUM_DIR-1:0] w_green_nxt;

    logic [DIR_W-1:0]   w_sel_dir;
    logic [NUM_DIR-1:0] w_active_oh;
    logic [NUM_DIR-1:0] w_next_oh;
    logic               w_rest;
    logic               w_tmr_zero;
    int                 w_best_dist;
    int                 w_dist;

    // Pick the demanding direction nearest after the active one in rotation
    // order; the active direction itself sits at distance NUM_DIR (last).
    always_comb begin
        w_sel_dir   = (r_active == c_last_dir) ? '0 : r_active + DIR_W'(1);
        w_best_dist = NUM_DIR + 1;
        w_dist      = 0;
        for (int i = 0; i < NUM_DIR; i++) begin
            if (demand[i]) begin
                w_dist = (i > int'(r_active)) ? (i - int'(r_active))
                                              : (i + NUM_DIR - int'(r_active));
                if (w_dist < w_best_dist) begin
                    w_best_dist = w_dist;
                    w_sel_dir   = DIR_W'(i);
                end
            end
        end
    end

    always_comb begin
        w_active_oh = '0;
        for (int i = 0; i < NUM_DIR; i++) begin
            w_active_oh[i] = (r_active == DIR_W'(i));
        end
    end

    assign w_rest     = (demand == w_active_oh);
    assign w_tmr_zero = (r_timer == '0);

    // State register, lamp registers included
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase     <= c_ph_allred;
            r_timer     <= c_allred_ld;
            r_active    <= c_last_dir;
            r_flash_on  <= 1'b1;
            r_flash_cnt <= c_flash_ld;
            r_red       <= '1;
            r_yellow    <= '0;
            r_green     <= '0;
        end else begin
            r_phase     <= w_phase_nxt;
            r_timer     <= w_timer_nxt;
            r_active    <= w_active_nxt;
            r_flash_on  <= w_flash_on_nxt;
            r_flash_cnt <= w_flash_cnt_nxt;
            r_red       <= w_red_nxt;
            r_yellow    <= w_yellow_nxt;
            r_green     <= w_green_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_phase_nxt     = r_phase;
        w_timer_nxt     = r_timer;
        w_active_nxt    = r_active;
        w_flash_on_nxt  = r_flash_on;
        w_flash_cnt_nxt = r_flash_cnt;
        case (r_phase)
            c_ph_allred: begin
                if (enable) begin
                    if (!w_tmr_zero) begin
                        w_timer_nxt = r_timer - TMR_W'(1);
                    end else if (flash_mode) begin
                        w_phase_nxt     = c_ph_flash;
                        w_flash_on_nxt  = 1'b1;
                        w_flash_cnt_nxt = c_flash_ld;
                    end else begin
                        w_phase_nxt  = c_ph_green;
                        w_active_nxt = w_sel_dir;
                        w_timer_nxt  = c_green_ld;
                    end
                end
            end
            c_ph_green: begin
                if (enable) begin
                    if (flash_mode || (w_tmr_zero && !w_rest)) begin
                        w_phase_nxt = c_ph_yellow;
                        w_timer_nxt = c_yellow_ld;
                    end else if (w_tmr_zero) begin
                        w_timer_nxt = c_green_ld;
                    end else begin
                        w_timer_nxt = r_timer - TMR_W'(1);
                    end
                end
            end
            c_ph_yellow: begin
                if (enable) begin
                    if (w_tmr_zero) begin
                        w_phase_nxt = c_ph_allred;
                        w_timer_nxt = c_allred_ld;
                    end else begin
                        w_timer_nxt = r_timer - TMR_W'(1);
                    end
                end
            end
            c_ph_flash: begin
                if (enable) begin
                    if (!flash_mode) begin
                        w_phase_nxt = c_ph_allred;
                        w_timer_nxt = c_allred_ld;
                    end else if (r_flash_cnt == '0) begin
                        w_flash_on_nxt  = ~r_flash_on;
                        w_flash_cnt_nxt = c_flash_ld;
                    end else begin
                        w_flash_cnt_nxt = r_flash_cnt - TMR_W'(1);
                    end
                end
            end
            default: begin
                w_phase_nxt = c_ph_allred;
                w_timer_nxt = c_allred_ld;
            end
        endcase
    end

    // Lamps are decoded from the next state so they change with the phase
    always_comb begin
        w_next_oh = '0;
        for (int i = 0; i < NUM_DIR; i++) begin
            w_next_oh[i] = (w_active_nxt == DIR_W'(i));
        end
        w_red_nxt    = '1;
        w_yellow_nxt = '0;
        w_green_nxt  = '0;
        case (w_phase_nxt)
            c_ph_green: begin
                w_green_nxt = w_next_oh;
                w_red_nxt   = ~w_next_oh;
            end
            c_ph_yellow: begin
                w_yellow_nxt = w_next_oh;
                w_red_nxt    = ~w_next_oh;
            end
            c_ph_flash: begin
                w_red_nxt    = '0;
                w_yellow_nxt = {NUM_DIR{w_flash_on_nxt}};
            end
            default: begin
                w_red_nxt = '1;
            end
        endcase
    end

    assign red        = r_red;
    assign yellow     = r_yellow;
    assign green      = r_green;
    assign active_dir = r_active;
    assign phase      = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_multi_dir_signal_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_dir_signal_ctrl
// Purpose  : Self-checking bench for multi_dir_signal_ctrl against a
//            remaining-cycles reference model of the signal sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_dir_signal_ctrl;

    localparam int N    = 4;
    localparam int DW   = 2;
    localparam int GRN  = 16;
    localparam int YEL  = 4;
    localparam int AR   = 2;
    localparam int FH   = 8;
    localparam int VW   = 3 * N + 2 + DW;
    localparam int P_AR = 0;
    localparam int P_G  = 1;
    localparam int P_Y  = 2;
    localparam int P_F  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          flash_mode = 1'b0;
    logic [N-1:0]  demand = '0;
    logic [N-1:0]  red, yellow, green;
    logic [DW-1:0] active_dir;
    logic [1:0]    phase;
    logic [VW-1:0] act_vec;

    int errors = 0;
    int checks = 0;

    // Reference model: phase, enabled cycles left in it, served direction
    int m_phase, m_left, m_dir, m_flash_left;
    bit m_flash_on;

    multi_dir_signal_ctrl #(
        .NUM_DIR(N), .GREEN_CYC(GRN), .YELLOW_CYC(YEL),
        .ALLRED_CYC(AR), .FLASH_HALF(FH), .TMR_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .flash_mode(flash_mode),
        .demand(demand), .red(red), .yellow(yellow), .green(green),
        .active_dir(active_dir), .phase(phase)
    );

    always #5 clk = ~clk;

    assign act_vec = {red, yellow, green, phase, active_dir};

    function automatic void model_reset();
        m_phase      = P_AR;
        m_left       = AR;
        m_dir        = N - 1;
        m_flash_on   = 1'b1;
        m_flash_left = FH;
    endfunction

    function automatic bit dem_bit(input int d);
        logic [N-1:0] sh;
        sh = demand >> d;
        return sh[0];
    endfunction

    function automatic int pick_dir();
        for (int k = 1; k <= N; k++) begin
            if (dem_bit((m_dir + k) % N)) return (m_dir + k) % N;
        end
        return (m_dir + 1) % N;
    endfunction

    function automatic bit only_mine();
        for (int i = 0; i < N; i++) begin
            if (dem_bit(i) != (i == m_dir)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model_step();
        if (!enable) return;
        case (m_phase)
            P_AR: begin
                m_left--;
                if (m_left == 0) begin
                    if (flash_mode) begin
                        m_phase = P_F; m_flash_on = 1'b1; m_flash_left = FH;
                    end else begin
                        m_dir = pick_dir(); m_phase = P_G; m_left = GRN;
                    end
                end
            end
            P_G: begin
                if (flash_mode) begin
                    m_phase = P_Y; m_left = YEL;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        if (only_mine()) m_left = GRN;
                        else begin m_phase = P_Y; m_left = YEL; end
                    end
                end
            end
            P_Y: begin
                m_left--;
                if (m_left == 0) begin m_phase = P_AR; m_left = AR; end
            end
            default: begin
                if (!flash_mode) begin
                    m_phase = P_AR; m_left = AR;
                end else begin
                    m_flash_left--;
                    if (m_flash_left == 0) begin
                        m_flash_on = ~m_flash_on; m_flash_left = FH;
                    end
                end
            end
        endcase
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [N-1:0] oh, r, y, g;
        for (int i = 0; i < N; i++) oh[i] = (i == m_dir);
        r = '1; y = '0; g = '0;
        case (m_phase)
            P_G:     begin g = oh; r = ~oh; end
            P_Y:     begin y = oh; r = ~oh; end
            P_F:     begin r = '0; y = {N{m_flash_on}}; end
            default: r = '1;
        endcase
        return {r, y, g, 2'(m_phase), DW'(m_dir)};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        demand = '0; enable = 1'b1; flash_mode = 1'b0;
        do_reset();
        checks++; if (red !== 4'b1111) begin errors++; $display("FAIL reset_red: got %b expected 1111", red); end
        checks++; if (yellow !== 4'b0000) begin errors++; $display("FAIL reset_yellow: got %b expected 0000", yellow); end
        checks++; if (green !== 4'b0000) begin errors++; $display("FAIL reset_green: got %b expected 0000", green); end
        checks++; if (phase !== 2'd0) begin errors++; $display("FAIL reset_phase: got %0d expected 0", phase); end
        checks++; if (active_dir !== 2'd3) begin errors++; $display("FAIL reset_active_dir: got %0d expected 3", active_dir); end
    endtask

    task automatic test_rotation();
        demand = '0; enable = 1'b1; flash_mode = 1'b0;
        do_reset();
        for (int e = 1; e <= 92; e++) begin
            tick();
            checks++;
            if (act_vec !== exp_vec()) begin errors++; $display("FAIL rotation_model e=%0d: got %h expected %h", e, act_vec, exp_vec()); end
            if (e == 1) begin checks++; if (red !== 4'b1111) begin errors++; $display("FAIL rotation_initial_red: got %b expected 1111", red); end end
            if (e == 2) begin checks++; if (green !== 4'b0001) begin errors++; $display("FAIL rotation_green0: got %b expected 0001", green); end end
            if (e == 18) begin checks++; if (yellow !== 4'b0001) begin errors++; $display("FAIL rotation_yellow0: got %b expected 0001", yellow); end end
            if (e == 22) begin checks++; if (red !== 4'b1111) begin errors++; $display("FAIL rotation_allred: got %b expected 1111", red); end end
            if (e == 24) begin checks++; if (green !== 4'b0010) begin errors++; $display("FAIL rotation_green1: got %b expected 0010", green); end end
            if (e == 90) begin checks++; if (green !== 4'b0001) begin errors++; $display("FAIL rotation_period: got %b expected 0001", green); end end
        end
    endtask

    task automatic test_skip();
        demand = 4'b1001; enable = 1'b1; flash_mode = 1'b0;
        do_reset();
        for (int e = 1; e <= 50; e++) begin
            tick();
            checks++;
            if (act_vec !== exp_vec()) begin errors++; $display("FAIL skip_model e=%0d: got %h expected %h", e, act_vec, exp_vec()); end
            if (e == 24) begin checks++; if (green !== 4'b1000) begin errors++; $display("FAIL skip_to_dir3: got %b expected 1000", green); end end
            if (e == 46) begin checks++; if (green !== 4'b0001) begin errors++; $display("FAIL skip_back_dir0: got %b expected 0001", green); end end
        end
    endtask

    task automatic test_rest_in_green();
        enable = 1'b1; flash_mode = 1'b0; demand = 4'b0001;
        do_reset();
        for (int e = 1; e <= 44; e++) begin
            demand = (e >= 22) ? 4'b0101 : 4'b0001;
            tick();
            checks++;
            if (act_vec !== exp_vec()) begin errors++; $display("FAIL rest_model e=%0d: got %h expected %h", e, act_vec, exp_vec()); end
            if (e == 20) begin checks++; if (green !== 4'b0001) begin errors++; $display("FAIL rest_hold: got %b expected 0001", green); end end
            if (e == 34) begin checks++; if (yellow !== 4'b0001) begin errors++; $display("FAIL rest_yellow: got %b expected 0001", yellow); end end
            if (e == 40) begin checks++; if (green !== 4'b0100) begin errors++; $display("FAIL rest_next_dir2: got %b expected 0100", green); end end
        end
    endtask

    task automatic test_flash();
        enable = 1'b1; flash_mode = 1'b0; demand = '0;
        do_reset();
        for (int e = 1; e <= 62; e++) begin
            flash_mode = (e >= 29 && e <= 56);
            tick();
            checks++;
            if (act_vec !== exp_vec()) begin errors++; $display("FAIL flash_model e=%0d: got %h expected %h", e, act_vec, exp_vec()); end
            if (e == 29) begin checks++; if (yellow !== 4'b0010) begin errors++; $display("FAIL flash_cut_yellow: got %b expected 0010", yellow); end end
            if (e == 33) begin checks++; if (red !== 4'b1111) begin errors++; $display("FAIL flash_allred: got %b expected 1111", red); end end
            if (e == 35) begin checks++; if (yellow !== 4'b1111) begin errors++; $display("FAIL flash_first_on: got %b expected 1111", yellow); end end
            if (e == 43) begin checks++; if (yellow !== 4'b0000) begin errors++; $display("FAIL flash_off: got %b expected 0000", yellow); end end
            if (e == 51) begin checks++; if (yellow !== 4'b1111) begin errors++; $display("FAIL flash_on_again: got %b expected 1111", yellow); end end
            if (e == 57) begin checks++; if (red !== 4'b1111) begin errors++; $display("FAIL flash_exit_allred: got %b expected 1111", red); end end
            if (e == 59) begin checks++; if (green !== 4'b0100) begin errors++; $display("FAIL flash_exit_green2: got %b expected 0100", green); end end
        end
        flash_mode = 1'b0;
    endtask

    task automatic test_enable_gap();
        int ycount;
        ycount = 0;
        enable = 1'b1; flash_mode = 1'b0; demand = '0;
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            enable = !(e >= 20 && e <= 29);
            tick();
            checks++;
            if (act_vec !== exp_vec()) begin errors++; $display("FAIL gap_model e=%0d: got %h expected %h", e, act_vec, exp_vec()); end
            if (yellow === 4'b0001) ycount++;
            if (e >= 20 && e <= 29) begin
                checks++;
                if ({phase, red, yellow, green} !== {2'd2, 4'b1110, 4'b0001, 4'b0000}) begin
                    errors++; $display("FAIL gap_frozen e=%0d: got ph=%0d r=%b y=%b g=%b expected ph=2 r=1110 y=0001 g=0000", e, phase, red, yellow, green);
                end
            end
        end
        enable = 1'b1;
        checks++; if (ycount != 14) begin errors++; $display("FAIL gap_yellow_len: got %0d expected 14", ycount); end
    endtask

    task automatic test_async_reset();
        enable = 1'b1; flash_mode = 1'b0; demand = '0;
        do_reset();
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++;
            if (act_vec !== exp_vec()) begin errors++; $display("FAIL areset_pre e=%0d: got %h expected %h", e, act_vec, exp_vec()); end
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (red !== 4'b1111) begin errors++; $display("FAIL areset_red: got %b expected 1111", red); end
        checks++; if (green !== 4'b0000) begin errors++; $display("FAIL areset_green: got %b expected 0000", green); end
        checks++; if (phase !== 2'd0) begin errors++; $display("FAIL areset_phase: got %0d expected 0", phase); end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks++; if (green !== 4'b0001) begin errors++; $display("FAIL areset_restart: got %b expected 0001", green); end
        checks++; if (act_vec !== exp_vec()) begin errors++; $display("FAIL areset_model: got %h expected %h", act_vec, exp_vec()); end
    endtask

    task automatic test_random();
        enable = 1'b1; flash_mode = 1'b0; demand = '0;
        do_reset();
        for (int e = 1; e <= 2000; e++) begin
            if ($urandom_range(3) == 0) demand = N'($urandom);
            enable = ($urandom_range(9) != 0);
            if ($urandom_range(63) == 0) flash_mode = ~flash_mode;
            tick();
            checks++;
            if (act_vec !== exp_vec()) begin errors++; $display("FAIL random_model e=%0d: got %h expected %h", e, act_vec, exp_vec()); end
            if (phase !== 2'd3) begin
                checks++;
                if ($countones(green | yellow) > 1 || (red ^ yellow ^ green) !== 4'b1111 ||
                    ((red & yellow) | (red & green) | (yellow & green)) !== 4'b0000) begin
                    errors++; $display("FAIL random_safety e=%0d: got r=%b y=%b g=%b expected one lamp per dir, <=1 non-red", e, red, yellow, green);
                end
            end
        end
        flash_mode = 1'b0; enable = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_rotation();
        test_skip();
        test_rest_in_green();
        test_flash();
        test_enable_gap();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_dir_signal_ctrl.md
Name: multi_dir_signal_ctrl

Overview:
Parametrised, timed traffic-signal sequencer for NUM_DIR approaches, the successor to the fixed two-road, four-state light decoder. It holds the phase state machine, the per-phase timers, demand-actuated direction selection with skipping and rest-in-green, and a flashing-yellow maintenance mode. It drives the red/yellow/green lamp vectors directly. It sits between the detector/demand logic and the lamp drivers.

Parameters:
NUM_DIR, 4, number of approaches (2..8); DIR_W = clog2(NUM_DIR) is derived internally.
GREEN_CYC, 16, green duration in clock cycles (>=1).
YELLOW_CYC, 4, yellow duration in cycles (>=1).
ALLRED_CYC, 2, all-red clearance duration in cycles (>=1).
FLASH_HALF, 8, flash-mode half-period in cycles (>=1).
TMR_W, 8, timer width; every *_CYC must be <= 2^TMR_W.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  timer advance; 0 freezes timer and state
flash_mode  in  1  request flashing-yellow mode
demand  in  NUM_DIR  per-direction vehicle demand, level-sensitive
red  out  NUM_DIR  red lamps, registered
yellow  out  NUM_DIR  yellow lamps, registered
green  out  NUM_DIR  green lamps, registered
active_dir  out  DIR_W  direction currently or most recently served
phase  out  2  0=ALL_RED, 1=GREEN, 2=YELLOW, 3=FLASH

Behaviour:
- Reset (async, while rst_n=0): phase=ALL_RED, timer=ALLRED_CYC-1, active_dir=NUM_DIR-1, red=all 1, yellow=0, green=0, flash toggle=on.
- Timer: on entry to a phase it loads (duration-1). It decrements each cycle with enable=1. The phase "expires" on a cycle with timer==0 and enable=1, and the transition takes effect on that edge. Each phase therefore lasts exactly its duration while enable is held at 1.
- enable=0: timer, phase, and outputs are held. Flash toggling is also frozen.
- ALL_RED expiry, flash_mode=0: selects next direction = first i in order active+1, active+2, ..., active (mod NUM_DIR) with demand[i]=1. If demand==0, next = active+1 mod NUM_DIR (fixed-time fallback). Sets active_dir=next and enters GREEN.
- ALL_RED expiry, flash_mode=1: enters FLASH.
- GREEN expiry: if demand[active]=1 and all other demand bits are 0, reloads GREEN_CYC-1 (rest-in-green). Otherwise enters YELLOW.
- GREEN with flash_mode=1: enters YELLOW on the next enabled edge regardless of timer. Green is never cut to red directly.
- YELLOW expiry: enters ALL_RED. flash_mode does not shorten YELLOW.
- FLASH: red=0, green=0, yellow=all equal to the flash toggle. The toggle starts on and inverts every FLASH_HALF enabled cycles. When flash_mode=0 is sampled, the block enters ALL_RED (ALLRED_CYC), then selects as normal.
- Outputs in non-FLASH phases: only the active direction may be green or yellow. Every other direction is red. In ALL_RED, all directions are red.
- Safety invariant, checkable every cycle: popcount(green|yellow) <= 1 outside FLASH. For each direction, exactly one of red/yellow/green is set outside FLASH.
- Outputs are registered. A lamp change is visible in the same cycle that phase changes.
- Demand changes mid-phase take effect only at the next expiry decision.
- An illegal phase encoding is unreachable. If it occurs, the block recovers to ALL_RED with all red.

Test Plan:
1. NUM_DIR=4, defaults, demand=0, enable=1, release reset: red=4'b1111 for 2 cycles; then green=4'b0001 for 16, yellow=4'b0001 for 4, all-red for 2, green=4'b0010. The full rotation period is 88 cycles.
2. demand=4'b1001 held, dir0 green: after dir0 yellow and all-red, green=4'b1000 (dirs 1 and 2 skipped). The next green is dir0.
3. demand=4'b0001 only: green[0] stays past 16 cycles. Raise demand[2] at cycle 20 of green: yellow[0] at cycle 32, then green[2] after 2 cycles of all-red.
4. Assert flash_mode at cycle 5 of dir1 green: yellow[1] next cycle for 4 cycles, all-red 2 cycles, then yellow=4'b1111/4'b0000 alternating every 8 cycles. Drop flash_mode: all-red 2 cycles, then green to dir2 (demand=0).
5. Drop enable for 10 cycles in the middle of yellow[0]: yellow lasts 14 cycles total, and all outputs are frozen during the gap.
6. Assert rst_n=0 asynchronously mid-green: red=all 1 and green=0 before the next clk edge. After release, green is on dir0 again after 2 cycles.
